// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// requester port indices and the legal range of the RAM address width.
package ram_arbiter_pkg;

    // Arbiter FSM states: waiting for a request, or one RAM access in flight.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Requester port indices; gnt and last hold one of these.
    localparam logic PORT_DMA = 1'b0;  // port 0: DMA engine
    localparam logic PORT_WIN = 1'b1;  // port 1: direct C64 window

    // Supported RAM word-address widths.
    localparam int RAM_A_BITS_MIN = 17;
    localparam int RAM_A_BITS_MAX = 24;

endpackage

// File: rtl/ram_arbiter_if.sv
// Toggle-handshake memory bus. The master drives address, write data,
// write enable and the request toggle; the slave answers with the
// acknowledge toggle and read data. A transfer is outstanding while
// req != ack and complete once ack == req.
interface ram_arbiter_if #(
    parameter int A_BITS = 17
);
    logic [A_BITS-1:0] a;
    logic [7:0]        d;
    logic              we;
    logic              req;
    logic              ack;
    logic [7:0]        q;

    // Requester (or the arbiter towards the RAM).
    modport master (
        output a, d, we, req,
        input  ack, q
    );

    // Responder (the arbiter towards a requester, or the RAM).
    modport slave (
        input  a, d, we, req,
        output ack, q
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single toggle-handshake RAM.
// Port 0 is the DMA engine, port 1 the direct C64 window. Exactly one RAM
// access is outstanding at a time; when both ports wait, the port that was
// not served last wins. All outputs come straight from registers.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_A_BITS = 17
) (
    input  logic           clk,
    input  logic           reset,
    ram_arbiter_if.slave   p0,
    ram_arbiter_if.slave   p1,
    ram_arbiter_if.master  ram
);

    // Reject unsupported address widths at elaboration time.
    if ((RAM_A_BITS < RAM_A_BITS_MIN) || (RAM_A_BITS > RAM_A_BITS_MAX)) begin : g_bad_width
        $error("ram_arbiter: RAM_A_BITS out of supported range");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_r;
    state_t                state_nxt_s;
    logic                  gnt_r;      // port currently (or last) in service
    logic                  last_r;     // port granted by the previous completed access

    logic [RAM_A_BITS-1:0] ram_a_r;
    logic [7:0]            ram_d_r;
    logic                  ram_we_r;
    logic                  ram_req_r;

    logic                  p0_ack_r;
    logic                  p1_ack_r;
    logic [7:0]            p0_q_r;
    logic [7:0]            p1_q_r;

    // Combinational control
    logic                  pend0_s;
    logic                  pend1_s;
    logic                  sel_s;      // port chosen if a grant happens this cycle
    logic                  grant_s;    // start a RAM access on this edge
    logic                  done_s;     // the RAM access completes on this edge

    // A port is pending when its toggles differ and it is not the one being
    // served right now (its own access would otherwise look pending too).
    assign pend0_s = (p0.req != p0_ack_r) &&
                     !((state_r == ST_BUSY) && (gnt_r == PORT_DMA));
    assign pend1_s = (p1.req != p1_ack_r) &&
                     !((state_r == ST_BUSY) && (gnt_r == PORT_WIN));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Advance the arbiter state; reset always lands in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // IDLE leaves as soon as anyone is pending; BUSY leaves when the RAM acks.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pend0_s || pend1_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ram.ack == ram_req_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output (control strobe) logic
    // ------------------------------------------------------------------
    // Decode grant/complete strobes and pick the winning port round-robin.
    always_comb begin
        grant_s = 1'b0;
        done_s  = 1'b0;
        sel_s   = PORT_DMA;

        // Contention goes to the port that was not served last; a lone
        // pending port always wins regardless of history.
        if (pend0_s && pend1_s) begin
            sel_s = ~last_r;
        end else if (pend1_s) begin
            sel_s = PORT_WIN;
        end else begin
            sel_s = PORT_DMA;
        end

        case (state_r)
            ST_IDLE: begin
                grant_s = pend0_s || pend1_s;
                done_s  = 1'b0;
            end
            ST_BUSY: begin
                grant_s = 1'b0;
                done_s  = (ram.ack == ram_req_r);
            end
            default: begin
                grant_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Latch the granted port's command towards the RAM and hold it while BUSY.
    // On reset ram_req follows ram_ack every cycle, so a RAM acknowledge
    // that lands during reset is absorbed instead of completing later.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_a_r   <= {RAM_A_BITS{1'b0}};
            ram_d_r   <= 8'h00;
            ram_we_r  <= 1'b0;
            ram_req_r <= ram.ack;
        end else if (grant_s) begin
            if (sel_s == PORT_WIN) begin
                ram_a_r  <= p1.a;
                ram_d_r  <= p1.d;
                ram_we_r <= p1.we;
            end else begin
                ram_a_r  <= p0.a;
                ram_d_r  <= p0.d;
                ram_we_r <= p0.we;
            end
            ram_req_r <= ~ram_req_r;
        end
    end

    // Record which port holds the RAM and which one finished most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r  <= PORT_DMA;
            last_r <= PORT_WIN;   // port 0 wins the first contention
        end else begin
            if (grant_s) begin
                gnt_r <= sel_s;
            end
            if (done_s) begin
                last_r <= gnt_r;
            end
        end
    end

    // Complete port 0: capture read data (writes leave q alone) and toggle ack.
    // Reset aligns ack with req, discarding anything pending or in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_ack_r <= p0.req;
            p0_q_r   <= 8'h00;
        end else if (done_s && (gnt_r == PORT_DMA)) begin
            p0_ack_r <= ~p0_ack_r;
            if (!ram_we_r) begin
                p0_q_r <= ram.q;
            end
        end
    end

    // Complete port 1: capture read data (writes leave q alone) and toggle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_ack_r <= p1.req;
            p1_q_r   <= 8'h00;
        end else if (done_s && (gnt_r == PORT_WIN)) begin
            p1_ack_r <= ~p1_ack_r;
            if (!ram_we_r) begin
                p1_q_r <= ram.q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram.a   = ram_a_r;
    assign ram.d   = ram_d_r;
    assign ram.we  = ram_we_r;
    assign ram.req = ram_req_r;

    assign p0.ack  = p0_ack_r;
    assign p0.q    = p0_q_r;
    assign p1.ack  = p1_ack_r;
    assign p1.q    = p1_q_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed requests on both ports against a
// fixed-latency toggle-handshake RAM model. Expected RAM commands and
// expected read data are queued when a request is issued; monitors pop and
// compare whenever the RAM sees a new request or a port acknowledges.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AB      = 17;
    localparam int RAM_LAT = 3;

    logic clk = 1'b0;
    logic reset;
    logic ram_init;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    ram_arbiter_if #(.A_BITS(AB)) p0_bus ();
    ram_arbiter_if #(.A_BITS(AB)) p1_bus ();
    ram_arbiter_if #(.A_BITS(AB)) ram_bus ();

    ram_arbiter #(.RAM_A_BITS(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_bus),
        .p1    (p1_bus),
        .ram   (ram_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AB-1:0] a;
        logic [7:0]    d;
        logic          we;
    } ram_op_t;

    ram_op_t    ram_exp[$];
    logic [7:0] q_exp0[$];
    logic [7:0] q_exp1[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Fixed read contents of the RAM model.
    function automatic logic [7:0] rd_val(logic [AB-1:0] a);
        case (a)
            17'h00123: rd_val = 8'h5A;
            17'h00140: rd_val = 8'h77;
            17'h00300: rd_val = 8'h99;
            default:   rd_val = a[7:0] ^ 8'hC3;
        endcase
    endfunction

    // RAM model: picks up a toggled request, answers RAM_LAT edges later.
    // Once committed it finishes even if the arbiter is reset meanwhile.
    logic          m_busy;
    int            m_cnt;
    logic [AB-1:0] m_a;
    logic          m_we;
    logic          m_req;
    always @(posedge clk) begin
        if (ram_init) begin
            ram_bus.ack <= 1'b0;
            ram_bus.q   <= 8'h00;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_a         <= '0;
            m_we        <= 1'b0;
            m_req       <= 1'b0;
        end else if (!m_busy) begin
            if (ram_bus.req !== ram_bus.ack) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_a    <= ram_bus.a;
                m_we   <= ram_bus.we;
                m_req  <= ram_bus.req;
            end
        end else if (m_cnt == RAM_LAT) begin
            m_busy      <= 1'b0;
            ram_bus.ack <= m_req;
            ram_bus.q   <= m_we ? 8'hEE : rd_val(m_a);
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Monitors: compare on every RAM request toggle and every port ack toggle.
    logic rst_seen;
    logic prev_ram_req, prev_ram_ack, prev_ack0, prev_ack1;
    int   grant_cyc, ram_ack_cyc, ack_cyc0, ack_cyc1;
    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (rst_seen === 1'b0 && ram_init === 1'b0) begin
            if (ram_bus.req !== prev_ram_req) begin
                grant_cyc <= cyc;
                if (ram_exp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ram_unexpected: request a=%0h we=%0b, none expected", ram_bus.a, ram_bus.we);
                end else begin
                    chk("ram_cmd {we,d,a}", {6'd0, ram_bus.we, ram_bus.d, ram_bus.a},
                        {6'd0, ram_exp[0].we, ram_exp[0].d, ram_exp[0].a});
                    void'(ram_exp.pop_front());
                end
            end
            if (ram_bus.ack !== prev_ram_ack) ram_ack_cyc <= cyc;
            if (p0_bus.ack !== prev_ack0) begin
                ack_cyc0 <= cyc;
                if (q_exp0.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL p0_unexpected_ack: q=%0h, no access expected", p0_bus.q);
                end else begin
                    chk("p0_q", {24'd0, p0_bus.q}, {24'd0, q_exp0[0]});
                    void'(q_exp0.pop_front());
                end
            end
            if (p1_bus.ack !== prev_ack1) begin
                ack_cyc1 <= cyc;
                if (q_exp1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL p1_unexpected_ack: q=%0h, no access expected", p1_bus.q);
                end else begin
                    chk("p1_q", {24'd0, p1_bus.q}, {24'd0, q_exp1[0]});
                    void'(q_exp1.pop_front());
                end
            end
        end
        prev_ram_req <= ram_bus.req;
        prev_ram_ack <= ram_bus.ack;
        prev_ack0    <= p0_bus.ack;
        prev_ack1    <= p1_bus.ack;
    end

    task automatic issue(input int port, input logic [AB-1:0] a, input logic [7:0] d,
                         input logic we, input logic [7:0] qexp, input bit push_ram);
        ram_op_t op;
        if (port == 0) begin
            p0_bus.a = a; p0_bus.d = d; p0_bus.we = we;
            p0_bus.req = ~p0_bus.req;
            q_exp0.push_back(qexp);
        end else begin
            p1_bus.a = a; p1_bus.d = d; p1_bus.we = we;
            p1_bus.req = ~p1_bus.req;
            q_exp1.push_back(qexp);
        end
        if (push_ram) begin
            op.a = a; op.d = d; op.we = we;
            ram_exp.push_back(op);
        end
    endtask

    task automatic wait_done(input int port);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (port == 0 ? (p0_bus.ack === p0_bus.req) : (p1_bus.ack === p1_bus.req)) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL timeout_p%0d: ack did not match req within 100 cycles", port);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int  issue_cyc;
    logic save0, save1;

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        p0_bus.a = '0; p0_bus.d = 8'h00; p0_bus.we = 1'b0; p0_bus.req = 1'b0;
        p1_bus.a = '0; p1_bus.d = 8'h00; p1_bus.we = 1'b0; p1_bus.req = 1'b0;
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ram_req_eq_ack", {31'd0, ram_bus.req}, {31'd0, ram_bus.ack});
        chk("rst_p0_ack", {31'd0, p0_bus.ack}, {31'd0, p0_bus.req});
        chk("rst_p1_ack", {31'd0, p1_bus.ack}, {31'd0, p1_bus.req});
        chk("rst_ram_a", {15'd0, ram_bus.a}, 32'h0);
        chk("rst_ram_d_we", {23'd0, ram_bus.we, ram_bus.d}, 32'h0);
        chk("rst_q", {16'd0, p0_bus.q, p1_bus.q}, 32'h0);

        // Simultaneous writes after reset: port 0 first, then port 1
        issue(0, 17'h00010, 8'hA5, 1'b1, 8'h00, 1'b1);
        issue(1, 17'h00020, 8'h3C, 1'b1, 8'h00, 1'b1);
        wait_done(0);
        wait_done(1);

        // Fairness: both re-request continuously; grants alternate 0,1,0,1...
        for (int i = 0; i < 4; i++) begin
            ram_op_t op;
            op.we = 1'b1;
            op.a = AB'(32'h100 + i); op.d = 8'(32'h10 + i); ram_exp.push_back(op);
            op.a = AB'(32'h200 + i); op.d = 8'(32'h20 + i); ram_exp.push_back(op);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(0, AB'(32'h100 + i), 8'(32'h10 + i), 1'b1, 8'h00, 1'b0);
                    wait_done(0);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    issue(1, AB'(32'h200 + j), 8'(32'h20 + j), 1'b1, 8'h00, 1'b0);
                    wait_done(1);
                end
            end
        join
        chk("fair_all_granted", ram_exp.size(), 32'd0);

        // Single read on port 0 with latency checks
        issue_cyc = cyc;
        issue(0, 17'h00123, 8'h00, 1'b0, 8'h5A, 1'b1);
        wait_done(0);
        chk("lat_grant", grant_cyc, issue_cyc + 1);
        chk("lat_ack", ack_cyc0, ram_ack_cyc + 1);
        chk("read_ram_a", {15'd0, ram_bus.a}, 32'h00123);
        chk("read_p0_q", {24'd0, p0_bus.q}, 32'h5A);

        // Contention after port 0 was served last: port 1 wins
        issue(0, 17'h00160, 8'h00, 1'b0, 8'hA3, 1'b0);
        issue(1, 17'h00161, 8'h00, 1'b0, 8'hA2, 1'b1);
        begin
            ram_op_t op;
            op.a = 17'h00160; op.d = 8'h00; op.we = 1'b0;
            ram_exp.push_back(op);
        end
        wait_done(1);
        wait_done(0);
        chk("rr_one_idle_cycle", grant_cyc, ack_cyc1 + 1);

        // Arrival during BUSY; command held stable while BUSY
        issue(0, 17'h00150, 8'h00, 1'b0, 8'h93, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_at_p1_issue", {31'd0, ram_bus.req ^ ram_bus.ack}, 32'd1);
        issue(1, 17'h00170, 8'h44, 1'b1, 8'hA2, 1'b1);
        p0_bus.a = 17'h1FFFF;
        @(negedge clk);
        chk("busy_ram_a_stable", {15'd0, ram_bus.a}, 32'h00150);
        wait_done(0);
        wait_done(1);
        chk("busy_p1_grant_after_p0_ack", grant_cyc, ack_cyc0 + 1);
        chk("busy_p0_q_kept", {24'd0, p0_bus.q}, 32'h93);

        // Write does not disturb q
        issue(1, 17'h00140, 8'h00, 1'b0, 8'h77, 1'b1);
        wait_done(1);
        issue(1, 17'h00180, 8'h11, 1'b1, 8'h77, 1'b1);
        wait_done(1);
        chk("wr_p1_q_kept", {24'd0, p1_bus.q}, 32'h77);
        chk("wr_p0_q_untouched", {24'd0, p0_bus.q}, 32'h93);

        // Reset mid-access: RAM acks while reset is held
        issue(0, 17'h00300, 8'h00, 1'b0, 8'h99, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q_exp0.delete();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ram_req_eq_ack", {31'd0, ram_bus.req}, {31'd0, ram_bus.ack});
        chk("mid_rst_p0_ack", {31'd0, p0_bus.ack}, {31'd0, p0_bus.req});
        chk("mid_rst_q", {16'd0, p0_bus.q, p1_bus.q}, 32'h0);
        save0 = p0_bus.ack;
        save1 = p1_bus.ack;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_ack_toggle", {30'd0, p0_bus.ack, p1_bus.ack}, {30'd0, save0, save1});

        // Next request after reset is served normally
        issue_cyc = cyc;
        issue(1, 17'h00155, 8'h00, 1'b0, 8'h96, 1'b1);
        wait_done(1);
        chk("post_rst_lat_grant", grant_cyc, issue_cyc + 1);
        chk("post_rst_p1_q", {24'd0, p1_bus.q}, 32'h96);

        chk("sb_drain", ram_exp.size() + q_exp0.size() + q_exp1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
